// File: rtl/voice_allocator_pkg.sv
// Shared constants, FSM encoding and semitone table for the voice allocator.
// Table entries are the top octave (MIDI 120..131) increments at 31.25 kHz, 21-bit.
// Lower octaves are derived by right-shifting the table entry.
package voice_allocator_pkg;

  localparam int NUM_VOICES_DEF   = 4;
  localparam int INC_WIDTH_DEF    = 20;
  localparam int RETRIG_TICKS_DEF = 2;
  localparam int SAMPLEFREQ       = 31250;
  localparam int TABLE_WIDTH      = 21;
  localparam int NOTE_WIDTH       = 7;
  localparam int MAX_OCTAVE       = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_LOOKUP = 3'd2,
    ST_RETRIG = 3'd3,
    ST_WRITE  = 3'd4
  } state_t;

  // round(f(120+semi) * 2^21 / SAMPLEFREQ)
  function automatic logic [TABLE_WIDTH-1:0] semitone_inc(input logic [3:0] semi);
    logic [TABLE_WIDTH-1:0] r;
    case (semi)
      4'd0:    r = 21'd561837;
      4'd1:    r = 21'd595245;
      4'd2:    r = 21'd630640;
      4'd3:    r = 21'd668140;
      4'd4:    r = 21'd707870;
      4'd5:    r = 21'd749962;
      4'd6:    r = 21'd794557;
      4'd7:    r = 21'd841804;
      4'd8:    r = 21'd891860;
      4'd9:    r = 21'd944893;
      4'd10:   r = 21'd1001079;
      4'd11:   r = 21'd1060606;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/voice_allocator_note_to_increment.sv
// MIDI note to phase increment: semitone table entry shifted down by (10 - octave).
// Latency: combinational; the caller registers the result.
// Backpressure: none.
module note_to_increment
  import voice_allocator_pkg::*;
#(
  parameter int INC_WIDTH = INC_WIDTH_DEF
) (
  input  logic [NOTE_WIDTH-1:0] i_note,
  output logic [INC_WIDTH-1:0]  o_inc
);

  logic [3:0]             w_oct;
  logic [3:0]             w_semi;
  logic [3:0]             w_shift;
  logic [TABLE_WIDTH-1:0] w_base;
  logic [TABLE_WIDTH-1:0] w_shifted;

  // Note 127 is octave 10, so the shift never goes negative.
  assign w_oct     = 4'(i_note / 7'd12);
  assign w_semi    = 4'(i_note % 7'd12);
  assign w_shift   = 4'(MAX_OCTAVE) - w_oct;
  assign w_base    = semitone_inc(w_semi);
  assign w_shifted = w_base >> w_shift;
  assign o_inc     = INC_WIDTH'(w_shifted);

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic note scheduler: assigns note-on/off events to voices (match, free, oldest steal).
// Latency: note-off 1 clk, note-on to free voice 3 clks, steal/retrigger waits RETRIG_TICKS samples.
// Backpressure: ev_ready high only when idle and panic is low; one event in flight at a time.
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES   = NUM_VOICES_DEF,
  parameter int INC_WIDTH    = INC_WIDTH_DEF,
  parameter int RETRIG_TICKS = RETRIG_TICKS_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sample_tick,
  input  logic                            panic,
  input  logic                            ev_valid,
  output logic                            ev_ready,
  input  logic                            ev_note_on,
  input  logic [NOTE_WIDTH-1:0]           ev_note,
  output logic [NUM_VOICES-1:0]           gate,
  output logic [NUM_VOICES*INC_WIDTH-1:0] pitch_increment,
  output logic                            busy
);

  localparam int RW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int TW = $clog2(RETRIG_TICKS + 1);
  localparam logic [RW-1:0] OLDEST_RANK = RW'(NUM_VOICES - 1);
  localparam logic [TW-1:0] TICK_LAST   = TW'(RETRIG_TICKS - 1);

  state_t                  r_state;
  logic                    r_note_on;
  logic [NOTE_WIDTH-1:0]   r_note;
  logic [RW-1:0]           r_target;
  logic [INC_WIDTH-1:0]    r_inc;
  logic [TW-1:0]           r_tick_cnt;
  logic [NUM_VOICES-1:0]   r_gate;
  logic [INC_WIDTH-1:0]    r_pitch [NUM_VOICES];
  logic [NOTE_WIDTH-1:0]   r_held  [NUM_VOICES];
  logic [RW-1:0]           r_rank  [NUM_VOICES];

  logic                    w_match_vld;
  logic                    w_free_vld;
  logic [RW-1:0]           w_match_idx;
  logic [RW-1:0]           w_free_idx;
  logic [RW-1:0]           w_oldest_idx;
  logic [RW-1:0]           w_on_target;
  logic [INC_WIDTH-1:0]    w_inc;

  note_to_increment #(.INC_WIDTH(INC_WIDTH)) u_note_to_increment (
    .i_note (r_note),
    .o_inc  (w_inc)
  );

  assign ev_ready    = (r_state == ST_IDLE) && !panic;
  assign busy        = (r_state != ST_IDLE);
  assign gate        = r_gate;
  assign w_on_target = w_match_vld ? w_match_idx : (w_free_vld ? w_free_idx : w_oldest_idx);

  // Voice search over registered state; walking downwards lets the lowest index win.
  always_comb begin
    w_match_vld  = 1'b0;
    w_match_idx  = '0;
    w_free_vld   = 1'b0;
    w_free_idx   = '0;
    w_oldest_idx = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (r_gate[v] && (r_held[v] == r_note)) begin
        w_match_vld = 1'b1;
        w_match_idx = RW'(v);
      end
      if (!r_gate[v]) begin
        w_free_vld = 1'b1;
        w_free_idx = RW'(v);
      end
      if (r_rank[v] == OLDEST_RANK) begin
        w_oldest_idx = RW'(v);
      end
    end
  end

  // Flatten per-voice increments onto the output bus.
  always_comb begin
    pitch_increment = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      pitch_increment[v*INC_WIDTH +: INC_WIDTH] = r_pitch[v];
    end
  end

  // Event FSM together with all per-voice state; panic overrides everything but reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_note_on  <= 1'b0;
      r_note     <= '0;
      r_target   <= '0;
      r_inc      <= '0;
      r_tick_cnt <= '0;
      r_gate     <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_pitch[v] <= '0;
        r_held[v]  <= '0;
        r_rank[v]  <= RW'(v);
      end
    end else if (panic) begin
      r_gate  <= '0;
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ev_valid) begin
            r_note_on <= ev_note_on;
            r_note    <= ev_note;
            r_state   <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (!r_note_on) begin
            if (w_match_vld) begin
              r_gate[w_match_idx] <= 1'b0;
            end
            r_state <= ST_IDLE;
          end else begin
            r_target <= w_on_target;
            r_state  <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          r_inc <= w_inc;
          // A sounding voice is silenced first so the envelope restarts cleanly.
          if (r_gate[r_target]) begin
            r_gate[r_target] <= 1'b0;
            r_tick_cnt       <= '0;
            r_state          <= ST_RETRIG;
          end else begin
            r_state <= ST_WRITE;
          end
        end
        ST_RETRIG: begin
          if (sample_tick) begin
            if (r_tick_cnt == TICK_LAST) begin
              r_state <= ST_WRITE;
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        ST_WRITE: begin
          r_gate[r_target]  <= 1'b1;
          r_pitch[r_target] <= r_inc;
          r_held[r_target]  <= r_note;
          // Target becomes newest; voices that were newer than it age by one.
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (RW'(v) == r_target) begin
              r_rank[v] <= '0;
            end else if (r_rank[v] < r_rank[r_target]) begin
              r_rank[v] <= r_rank[v] + 1'b1;
            end
          end
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed scenarios plus random events
// compared against a behavioural model (age list, real-valued pitch formula).
// Inputs driven and outputs sampled on the falling edge.
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int IW = 20;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            sample_tick = 1'b0;
  logic            panic = 1'b0;
  logic            ev_valid = 1'b0;
  logic            ev_ready;
  logic            ev_note_on = 1'b0;
  logic [6:0]      ev_note = '0;
  logic [NV-1:0]   gate;
  logic [NV*IW-1:0] pitch_increment;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit tick_at_edge;

  // Model: gate/held/increment per voice, and voices ordered newest first.
  int m_gate [NV];
  int m_held [NV];
  int m_inc  [NV];
  int m_age  [$];

  voice_allocator dut (
    .clk             (clk),
    .rst             (rst),
    .sample_tick     (sample_tick),
    .panic           (panic),
    .ev_valid        (ev_valid),
    .ev_ready        (ev_ready),
    .ev_note_on      (ev_note_on),
    .ev_note         (ev_note),
    .gate            (gate),
    .pitch_increment (pitch_increment),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_inc(input int note);
    int  oct  = note / 12;
    int  semi = note % 12;
    real f    = 440.0 * $pow(2.0, (real'(120 + semi) - 69.0) / 12.0);
    int  tab  = $rtoi(f * 2097152.0 / 31250.0 + 0.5);
    return (tab >> (10 - oct)) & ((1 << IW) - 1);
  endfunction

  function automatic int pitch_of(input int v);
    return {12'b0, pitch_increment[v*IW +: IW]};
  endfunction

  task automatic model_reset();
    m_age.delete();
    for (int v = 0; v < NV; v++) begin
      m_gate[v] = 0;
      m_held[v] = 0;
      m_inc[v]  = 0;
      m_age.push_back(v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    tick_at_edge = sample_tick;
    @(negedge clk);
    sample_tick = ($urandom_range(0, 2) == 0);
  endtask

  task automatic check_outputs(input string tag);
    for (int v = 0; v < NV; v++) begin
      chk($sformatf("%s gate%0d", tag, v), gate[v], m_gate[v]);
      chk($sformatf("%s inc%0d", tag, v), pitch_of(v), m_inc[v]);
    end
    chk({tag, " rdy"}, ev_ready, 1);
    chk({tag, " busy"}, busy, 0);
  endtask

  task automatic do_event(input bit on, input int note, input string tag);
    int t = -1, match = -1, free = -1;
    bit retrig;
    int pre_gate [NV];
    int pre_pitch [NV];
    int cycles = 0, ticks = 0;
    bit fell = 0, glitch = 0;
    for (int v = 0; v < NV; v++) begin
      if (match < 0 && m_gate[v] != 0 && m_held[v] == note) match = v;
      if (free < 0 && m_gate[v] == 0) free = v;
      pre_gate[v]  = gate[v];
      pre_pitch[v] = pitch_of(v);
    end
    if (!on) t = match;
    else t = (match >= 0) ? match : ((free >= 0) ? free : m_age[m_age.size()-1]);
    retrig = on && (m_gate[t] != 0);

    chk({tag, " rdy_in"}, ev_ready, 1);
    ev_valid = 1'b1; ev_note_on = on; ev_note = 7'(note);
    step();
    ev_valid = 1'b0;
    while (busy && cycles < 200) begin
      step();
      cycles++;
      if (t >= 0) begin
        if (fell && !gate[t]) ticks += int'(tick_at_edge);
        if (pre_gate[t] != 0 && !gate[t]) fell = 1;
      end
      for (int v = 0; v < NV; v++) begin
        if (v != t) begin
          if (gate[v] != pre_gate[v][0] || pitch_of(v) != pre_pitch[v]) glitch = 1;
        end else if (pitch_of(v) != pre_pitch[v] && !gate[v]) begin
          glitch = 1;
        end
      end
    end
    chk({tag, " done"}, busy, 0);
    if (!on) chk({tag, " lat"}, cycles, 1);
    else if (!retrig) chk({tag, " lat"}, cycles, 3);
    else begin
      chk({tag, " fell"}, fell, 1);
      chk({tag, " ticks"}, ticks, 2);
    end
    chk({tag, " glitch"}, glitch, 0);

    if (!on) begin
      if (t >= 0) m_gate[t] = 0;
    end else begin
      m_gate[t] = 1;
      m_held[t] = note;
      m_inc[t]  = exp_inc(note);
      for (int i = 0; i < m_age.size(); i++) begin
        if (m_age[i] == t) begin
          m_age.delete(i);
          break;
        end
      end
      m_age.push_front(t);
    end
    check_outputs(tag);
  endtask

  initial begin
    int t;
    int k;
    model_reset();
    repeat (3) step();
    chk("rst_hold gate", gate, 0);
    chk("rst_hold busy", busy, 0);
    rst = 1'b1;
    step();
    check_outputs("reset");

    // First note lands on voice 0 with the A4 increment.
    do_event(1, 69, "t2");
    chk("t2 abs inc0", pitch_of(0), 29527);
    do_event(0, 69, "off69");

    do_event(1, 60, "t3_60");
    chk("t3 abs inc0", pitch_of(0), 17557);
    do_event(1, 62, "t3_62");
    do_event(1, 64, "t3_64");
    do_event(1, 65, "t3_65");
    do_event(1, 67, "t3_67");
    chk("t3 abs inc0b", pitch_of(0), 26306);

    do_event(0, 62, "t4_off62");
    do_event(1, 72, "t4_72");
    chk("t4 abs inc1", pitch_of(1), 35114);

    do_event(1, 64, "t5_64");

    // Panic while a retrigger is waiting on sample ticks.
    t = -1;
    for (int v = 0; v < NV; v++) if (t < 0 && m_gate[v] != 0 && m_held[v] == 65) t = v;
    chk("pan target", t, 3);
    ev_valid = 1'b1; ev_note_on = 1'b1; ev_note = 7'd65;
    step();
    ev_valid = 1'b0;
    k = 0;
    while (gate[3] && k < 50) begin
      step();
      k++;
    end
    chk("pan fell", gate[3], 0);
    chk("pan busy_in", busy, 1);
    panic = 1'b1; ev_valid = 1'b1; ev_note = 7'd70;
    #1;
    chk("pan rdy_lo", ev_ready, 0);
    step();
    chk("pan gates", gate, 0);
    chk("pan busy", busy, 0);
    chk("pan rdy_still_lo", ev_ready, 0);
    step();
    chk("pan no_xfer", busy, 0);
    panic = 1'b0; ev_valid = 1'b0;
    #1;
    for (int v = 0; v < NV; v++) m_gate[v] = 0;
    check_outputs("pan");

    // Reset pulse while the next note-on sits in LOOKUP.
    ev_valid = 1'b1; ev_note_on = 1'b1; ev_note = 7'd60;
    step();
    ev_valid = 1'b0;
    step();
    chk("lk busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("lk rst gate", gate, 0);
    chk("lk rst pitch", pitch_increment, 0);
    chk("lk rst busy", busy, 0);
    chk("lk rst rdy", ev_ready, 1);
    step();
    step();
    rst = 1'b1;
    model_reset();
    step();
    check_outputs("post_rst");

    // Note range extremes and an unmatched note-off.
    do_event(1, 0, "b_on0");
    do_event(1, 127, "b_on127");
    do_event(0, 127, "b_off127");
    do_event(0, 5, "b_off5");
    do_event(1, 0, "b_re0");

    for (int i = 0; i < 80; i++) begin
      bit on = ($urandom_range(0, 9) < 7);
      int note = ($urandom_range(0, 1) == 1) ? 58 + int'($urandom_range(0, 5))
                                             : int'($urandom_range(0, 127));
      do_event(on, note, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
